// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and branch
// interlocks, multi-cycle divider occupancy, and exception redirect.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   S_IDLE     | normal operation, exceptions in M may be taken
//   S_REDIRECT | one cycle after an exception: fetch restarts at newpc
module pipe_hazard_ctrl #(
  parameter int                 RADDR_W    = 5,
  parameter int                 DATA_W     = 32,
  parameter int                 DIV_CYCLES = 32,
  parameter logic [DATA_W-1:0]  EXC_VECTOR = 32'hBFC00380,
  parameter logic [31:0]        ERET_CODE  = 32'h0000000E
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RADDR_W-1:0] rsD,
  input  logic [RADDR_W-1:0] rtD,
  input  logic [RADDR_W-1:0] rsE,
  input  logic [RADDR_W-1:0] rtE,
  input  logic [RADDR_W-1:0] reg_waddrE,
  input  logic [RADDR_W-1:0] reg_waddrM,
  input  logic [RADDR_W-1:0] reg_waddrW,
  input  logic               regwriteE,
  input  logic               regwriteM,
  input  logic               regwriteW,
  input  logic               memtoRegE,
  input  logic               memtoRegM,
  input  logic               branchD,
  input  logic               jrD,
  input  logic               div_startE,
  input  logic               i_stall,
  input  logic               d_stall,
  input  logic [31:0]        excepttypeM,
  input  logic [DATA_W-1:0]  cp0_epcM,
  output logic               stallF,
  output logic               stallD,
  output logic               stallE,
  output logic               stallM,
  output logic               stallW,
  output logic               flushD,
  output logic               flushE,
  output logic               flushM,
  output logic               flushW,
  output logic               forwardAD,
  output logic               forwardBD,
  output logic [1:0]         forwardAE,
  output logic [1:0]         forwardBE,
  output logic               div_busy,
  output logic               pc_redirect,
  output logic [DATA_W-1:0]  newpc
);

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {S_IDLE, S_REDIRECT} state_t;

  state_t           state;
  logic [CNT_W-1:0] div_cnt;
  logic             mem_stall;
  logic             lw_stall;
  logic             ctl_stall;
  logic             exc_take;
  logic             hitE_rs, hitE_rt, hitM_rs, hitM_rt;
  logic             base_stall_fd, base_stall_e;

  assign mem_stall = i_stall | d_stall;

  // Exceptions are only taken once the memory stage has stopped waiting on the bus.
  assign exc_take = (state == S_IDLE) && (excepttypeM != 32'h0) && !mem_stall;

  assign forwardAD = (rsD != '0) && regwriteM && (rsD == reg_waddrM);
  assign forwardBD = (rtD != '0) && regwriteM && (rtD == reg_waddrM);

  // E-stage forwarding select, the younger M result wins over W.
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if ((rsE != '0) && regwriteM && (rsE == reg_waddrM))      forwardAE = 2'b10;
    else if ((rsE != '0) && regwriteW && (rsE == reg_waddrW)) forwardAE = 2'b01;
    if ((rtE != '0) && regwriteM && (rtE == reg_waddrM))      forwardBE = 2'b10;
    else if ((rtE != '0) && regwriteW && (rtE == reg_waddrW)) forwardBE = 2'b01;
  end

  assign lw_stall = memtoRegE && (reg_waddrE != '0) &&
                    ((rsD == reg_waddrE) || (rtD == reg_waddrE));

  assign hitE_rs = regwriteE && (reg_waddrE != '0) && (rsD == reg_waddrE);
  assign hitE_rt = regwriteE && (reg_waddrE != '0) && (rtD == reg_waddrE);
  assign hitM_rs = memtoRegM && (reg_waddrM != '0) && (rsD == reg_waddrM);
  assign hitM_rt = memtoRegM && (reg_waddrM != '0) && (rtD == reg_waddrM);

  // Branches resolve in D and need both operands; jr only reads rs.
  assign ctl_stall = (branchD && (hitE_rs || hitE_rt || hitM_rs || hitM_rt)) ||
                     (jrD && (hitE_rs || hitM_rs));

  assign base_stall_fd = lw_stall | ctl_stall | div_busy | mem_stall;
  assign base_stall_e  = div_busy | mem_stall;

  assign stallF = base_stall_fd & ~exc_take;
  assign stallD = base_stall_fd & ~exc_take;
  assign stallE = base_stall_e  & ~exc_take;
  assign stallM = mem_stall     & ~exc_take;
  assign stallW = mem_stall     & ~exc_take;

  // A bubble into E only makes sense while E is actually advancing.
  assign flushD = exc_take | (state == S_REDIRECT);
  assign flushE = exc_take | ((lw_stall | ctl_stall) & ~div_busy & ~mem_stall);
  assign flushM = exc_take;
  assign flushW = exc_take;

  // Divider occupancy counter: counts down to zero, frozen by bus waits.
  always_ff @(posedge clk) begin
    if (rst || exc_take) begin
      div_cnt  <= '0;
      div_busy <= 1'b0;
    end else if (div_busy) begin
      if (!mem_stall) begin
        if (div_cnt == '0) div_busy <= 1'b0;
        else               div_cnt  <= div_cnt - CNT_W'(1);
      end
    end else if (div_startE) begin
      div_cnt  <= DIV_LOAD;
      div_busy <= 1'b1;
    end
  end

  // Exception FSM with registered redirect pulse and target PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc_redirect <= 1'b0;
      newpc       <= EXC_VECTOR;
    end else begin
      case (state)
        S_IDLE: begin
          pc_redirect <= 1'b0;
          if (exc_take) begin
            state       <= S_REDIRECT;
            pc_redirect <= 1'b1;
            newpc       <= (excepttypeM == ERET_CODE) ? cp0_epcM : EXC_VECTOR;
          end
        end
        default: begin
          state       <= S_IDLE;
          pc_redirect <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (divider shortened to 4 cycles).
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rsD, rtD, rsE, rtE, reg_waddrE, reg_waddrM, reg_waddrW;
  logic        regwriteE, regwriteM, regwriteW, memtoRegE, memtoRegM;
  logic        branchD, jrD, div_startE, i_stall, d_stall;
  logic [31:0] excepttypeM, cp0_epcM;
  logic        stallF, stallD, stallE, stallM, stallW;
  logic        flushD, flushE, flushM, flushW, forwardAD, forwardBD;
  logic [1:0]  forwardAE, forwardBE;
  logic        div_busy, pc_redirect;
  logic [31:0] newpc;

  int errors = 0;
  int checks = 0;
  int cnt;

  pipe_hazard_ctrl #(.DIV_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .reg_waddrE(reg_waddrE), .reg_waddrM(reg_waddrM), .reg_waddrW(reg_waddrW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoRegE(memtoRegE), .memtoRegM(memtoRegM),
    .branchD(branchD), .jrD(jrD), .div_startE(div_startE),
    .i_stall(i_stall), .d_stall(d_stall),
    .excepttypeM(excepttypeM), .cp0_epcM(cp0_epcM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .div_busy(div_busy), .pc_redirect(pc_redirect), .newpc(newpc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    reg_waddrE = 0; reg_waddrM = 0; reg_waddrW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    memtoRegE = 0; memtoRegM = 0; branchD = 0; jrD = 0;
    div_startE = 0; i_stall = 0; d_stall = 0;
    excepttypeM = 0; cp0_epcM = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_div_busy", 32'(div_busy), 0);
    chk("rst_pc_redirect", 32'(pc_redirect), 0);
    chk("rst_newpc", newpc, 32'hBFC00380);
    chk("rst_stallE", 32'(stallE), 0);

    // load-use interlock
    memtoRegE = 1; reg_waddrE = 8; rsD = 8; #1;
    chk("lu_stallF", 32'(stallF), 1);
    chk("lu_stallD", 32'(stallD), 1);
    chk("lu_flushE", 32'(flushE), 1);
    chk("lu_stallE", 32'(stallE), 0);
    reg_waddrE = 0; rsD = 0; #1;
    chk("lu_zero_stallD", 32'(stallD), 0);
    chk("lu_zero_flushE", 32'(flushE), 0);
    idle_inputs(); #1;

    // forwarding priority
    rsE = 5; reg_waddrM = 5; reg_waddrW = 5; regwriteM = 1; regwriteW = 1; rsD = 5; #1;
    chk("fwd_AE_M", 32'(forwardAE), 2);
    chk("fwd_BE_zero", 32'(forwardBE), 0);
    chk("fwd_AD", 32'(forwardAD), 1);
    regwriteM = 0; #1;
    chk("fwd_AE_W", 32'(forwardAE), 1);
    chk("fwd_AD_off", 32'(forwardAD), 0);
    regwriteW = 0; #1;
    chk("fwd_AE_none", 32'(forwardAE), 0);
    idle_inputs(); #1;

    // branch / jr interlocks
    branchD = 1; rtD = 9; rsD = 3; regwriteE = 1; reg_waddrE = 9; #1;
    chk("br_stallD", 32'(stallD), 1);
    chk("br_flushE", 32'(flushE), 1);
    branchD = 0; jrD = 1; #1;
    chk("jr_rt_ignored", 32'(stallD), 0);
    rsD = 9; #1;
    chk("jr_rs_stall", 32'(stallD), 1);
    idle_inputs(); #1;

    // plain divide, 4 busy cycles
    div_startE = 1;
    step();
    div_startE = 0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (div_busy) cnt++;
      if (i == 0) chk("div_stallE", 32'(stallE), 1);
      if (i == 0) chk("div_stallD", 32'(stallD), 1);
      step();
    end
    chk("div_busy_cycles", cnt, 4);
    chk("div_done_stallE", 32'(stallE), 0);

    // divide with a two-cycle fetch wait inside it
    div_startE = 1;
    step();
    div_startE = 0;
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      i_stall = (i == 1 || i == 2);
      #1;
      if (div_busy) cnt++;
      if (i == 1) chk("divst_stallM", 32'(stallM), 1);
      step();
    end
    i_stall = 0;
    chk("divst_busy_cycles", cnt, 6);

    // syscall mid-divide
    div_startE = 1;
    step();
    div_startE = 0;
    step();
    excepttypeM = 32'h8; #1;
    chk("sys_div_busy_pre", 32'(div_busy), 1);
    chk("sys_flushD", 32'(flushD), 1);
    chk("sys_flushE", 32'(flushE), 1);
    chk("sys_flushM", 32'(flushM), 1);
    chk("sys_flushW", 32'(flushW), 1);
    chk("sys_stallE", 32'(stallE), 0);
    chk("sys_stallF", 32'(stallF), 0);
    step();
    excepttypeM = 0; #1;
    chk("sys_div_busy", 32'(div_busy), 0);
    chk("sys_redirect", 32'(pc_redirect), 1);
    chk("sys_redir_flushD", 32'(flushD), 1);
    chk("sys_newpc", newpc, 32'hBFC00380);
    step();
    chk("sys_redirect_end", 32'(pc_redirect), 0);
    chk("sys_flushD_end", 32'(flushD), 0);
    chk("sys_stallE_end", 32'(stallE), 0);

    // ERET held off by data-bus wait
    excepttypeM = 32'hE; cp0_epcM = 32'h80001234; d_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("eret_wait_flushM", 32'(flushM), 0);
      chk("eret_wait_stallW", 32'(stallW), 1);
      step();
      chk("eret_wait_redirect", 32'(pc_redirect), 0);
    end
    d_stall = 0; #1;
    chk("eret_flushM", 32'(flushM), 1);
    step();
    excepttypeM = 0; #1;
    chk("eret_redirect", 32'(pc_redirect), 1);
    chk("eret_newpc", newpc, 32'h80001234);
    step();
    chk("eret_redirect_end", 32'(pc_redirect), 0);
    step();
    chk("eret_newpc_hold", newpc, 32'h80001234);

    // reset during REDIRECT
    excepttypeM = 32'hE; cp0_epcM = 32'h80005678;
    step();
    excepttypeM = 0; #1;
    chk("rr_redirect", 32'(pc_redirect), 1);
    chk("rr_newpc_pre", newpc, 32'h80005678);
    rst = 1;
    step();
    rst = 0; #1;
    chk("rr_redirect_cleared", 32'(pc_redirect), 0);
    chk("rr_newpc", newpc, 32'hBFC00380);
    chk("rr_flushD", 32'(flushD), 0);

    // reset mid-divide
    div_startE = 1;
    step();
    div_startE = 0; #1;
    chk("rd_busy_pre", 32'(div_busy), 1);
    rst = 1;
    step();
    rst = 0; #1;
    chk("rd_busy", 32'(div_busy), 0);
    chk("rd_stallE", 32'(stallE), 0);
    step();
    chk("rd_busy_stays", 32'(div_busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
